snake_game_ctrl: RTL and testbench

//  Central sequencer for the snake game: owns the game-state FSM (idle/difficulty

---
 rtl/snake_pkg.sv | 32 +++
 rtl/snake_tick_timer.sv | 40 ++++
 rtl/snake_game_ctrl.sv | 179 +++++++++++++++++
 tb/tb_snake_game_ctrl.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// Shared codes for the snake game controller: game states, headings,
// key strobe codes, body length limits and the heading-reversal helper.
package snake_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_INIT  = 3'd1,
    ST_RUN   = 3'd2,
    ST_OVER  = 3'd3,
    ST_PAUSE = 3'd4
  } state_e;

  localparam logic [1:0] DIR_PX = 2'd0;
  localparam logic [1:0] DIR_PY = 2'd1;
  localparam logic [1:0] DIR_NX = 2'd2;
  localparam logic [1:0] DIR_NY = 2'd3;

  localparam logic [3:0] KEY_UP    = 4'd1;
  localparam logic [3:0] KEY_DOWN  = 4'd2;
  localparam logic [3:0] KEY_LEFT  = 4'd3;
  localparam logic [3:0] KEY_RIGHT = 4'd4;
  localparam logic [3:0] KEY_S2    = 4'd5;

  localparam logic [3:0] INIT_LEN = 4'd4;
  localparam logic [3:0] MAX_LEN  = 4'd10;

  // Headings are encoded so that the reverse direction differs in bit 1.
  function automatic logic [1:0] opposite(input logic [1:0] d);
    return d ^ 2'b10;
  endfunction

endpackage

// File: rtl/snake_tick_timer.sv
// Move-period counter: clr_i zeroes, en_i counts 0..speed_i-1 and wraps,
// otherwise holds. Ports: clk_i, rst_ni, clr_i, en_i, speed_i -> tick_o (comb).
module snake_tick_timer #(
  parameter int CNT_W = 24
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] speed_i,
  output logic             tick_o
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             last;

  assign last   = (cnt_q == speed_i - ONE);
  assign tick_o = en_i & last;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = last ? '0 : cnt_q + ONE;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/snake_game_ctrl.sv
// Snake game sequencer: state FSM, move timer, heading with reversal lockout,
// grow/respawn strobes. In: key_out, hit, head_on_food, food_on_body.
// Out: game_state, init_pulse, move_tick, dir, grow_req, food_respawn, snake_len.
module snake_game_ctrl
  import snake_pkg::*;
#(
  parameter int               CNT_W      = 24,
  parameter logic [CNT_W-1:0] SPEED_EASY = 24'd15_000_000,
  parameter logic [CNT_W-1:0] SPEED_MED  = 24'd10_000_000,
  parameter logic [CNT_W-1:0] SPEED_HARD = 24'd5_000_000
) (
  input  logic       vga_clk,
  input  logic       sys_rst_n,
  input  logic [3:0] key_out,
  input  logic       hit,
  input  logic       head_on_food,
  input  logic       food_on_body,
  output logic [2:0] game_state,
  output logic       init_pulse,
  output logic       move_tick,
  output logic [1:0] dir,
  output logic       grow_req,
  output logic       food_respawn,
  output logic [3:0] snake_len
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] speed_q, speed_d;
  logic [1:0]       dir_q, dir_d;
  logic [1:0]       pend_q, pend_d;
  logic [3:0]       len_q, len_d;
  logic             init_q, init_d;
  logic             move_q, move_d;
  logic             grow_q, grow_d;
  logic             resp_q, resp_d;
  logic             hof_q;

  logic             go;
  logic             tick;
  logic             key_vld;
  logic [1:0]       key_dir;

  // Timer only advances on cycles that stay in RUN, so a pause or hit
  // arriving with a due tick leaves the count parked at speed-1.
  snake_tick_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk_i   (vga_clk),
    .rst_ni  (sys_rst_n),
    .clr_i   (state_q == ST_INIT),
    .en_i    (go),
    .speed_i (speed_q),
    .tick_o  (tick)
  );

  always_comb begin
    state_d = state_q;
    speed_d = speed_q;
    unique case (state_q)
      ST_IDLE: begin
        unique case (1'b1)
          (key_out == KEY_UP): begin
            speed_d = SPEED_HARD;
            state_d = ST_INIT;
          end
          (key_out == KEY_DOWN): begin
            speed_d = SPEED_MED;
            state_d = ST_INIT;
          end
          (key_out == KEY_LEFT): begin
            speed_d = SPEED_EASY;
            state_d = ST_INIT;
          end
          default: ;
        endcase
      end
      ST_INIT:  state_d = ST_RUN;
      ST_RUN: begin
        if (hit) begin
          state_d = ST_OVER;
        end else if (key_out == KEY_S2) begin
          state_d = ST_PAUSE;
        end
      end
      ST_PAUSE: if (key_out == KEY_S2) state_d = ST_RUN;
      ST_OVER:  if (key_out == KEY_S2) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  assign go = (state_q == ST_RUN) && (state_d == ST_RUN);

  always_comb begin
    key_vld = 1'b0;
    key_dir = DIR_PX;
    unique case (1'b1)
      (key_out == KEY_UP): begin
        key_vld = 1'b1;
        key_dir = DIR_NY;
      end
      (key_out == KEY_DOWN): begin
        key_vld = 1'b1;
        key_dir = DIR_PY;
      end
      (key_out == KEY_LEFT): begin
        key_vld = 1'b1;
        key_dir = DIR_NX;
      end
      (key_out == KEY_RIGHT): begin
        key_vld = 1'b1;
        key_dir = DIR_PX;
      end
      default: ;
    endcase
  end

  always_comb begin
    dir_d  = dir_q;
    pend_d = pend_q;
    len_d  = len_q;
    init_d = (state_d == ST_INIT);
    move_d = tick;
    grow_d = 1'b0;
    resp_d = 1'b0;
    if (state_d == ST_INIT) begin
      dir_d  = DIR_PX;
      pend_d = DIR_PX;
      len_d  = INIT_LEN;
    end
    if (tick) begin
      dir_d = pend_q;
    end
    // Check against the heading that will be in force after this cycle,
    // so a key landing on a tick cannot queue a reversal.
    if (go && key_vld && (key_dir != opposite(dir_d))) begin
      pend_d = key_dir;
    end
    if (go && head_on_food && !hof_q && (len_q != MAX_LEN)) begin
      grow_d = 1'b1;
      len_d  = len_q + 4'd1;
    end
    resp_d = go && food_on_body && !resp_q;
  end

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= ST_IDLE;
      speed_q <= SPEED_EASY;
      dir_q   <= DIR_PX;
      pend_q  <= DIR_PX;
      len_q   <= INIT_LEN;
      init_q  <= 1'b0;
      move_q  <= 1'b0;
      grow_q  <= 1'b0;
      resp_q  <= 1'b0;
      hof_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      speed_q <= speed_d;
      dir_q   <= dir_d;
      pend_q  <= pend_d;
      len_q   <= len_d;
      init_q  <= init_d;
      move_q  <= move_d;
      grow_q  <= grow_d;
      resp_q  <= resp_d;
      hof_q   <= head_on_food;
    end
  end

  assign game_state   = state_q;
  assign init_pulse   = init_q;
  assign move_tick    = move_q;
  assign dir          = dir_q;
  assign grow_req     = grow_q;
  assign food_respawn = resp_q;
  assign snake_len    = len_q;

endmodule

// File: tb/tb_snake_game_ctrl.sv
// Bench for snake_game_ctrl with short move periods (easy 8, med 6, hard 4).
// Expected output events are queued by the stimulus and matched by a monitor.
module tb_snake_game_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] key_out = 4'd0;
  logic       hit = 1'b0;
  logic       hof = 1'b0;
  logic       fob = 1'b0;
  logic [2:0] game_state;
  logic       init_pulse;
  logic       move_tick;
  logic [1:0] dir;
  logic       grow_req;
  logic       food_respawn;
  logic [3:0] snake_len;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] INIT = 3'd1;
  localparam logic [2:0] RUN  = 3'd2;
  localparam logic [2:0] OVER = 3'd3;
  localparam logic [2:0] PAUS = 3'd4;

  snake_game_ctrl #(
    .CNT_W      (24),
    .SPEED_EASY (24'd8),
    .SPEED_MED  (24'd6),
    .SPEED_HARD (24'd4)
  ) dut (
    .vga_clk      (clk),
    .sys_rst_n    (rst_n),
    .key_out      (key_out),
    .hit          (hit),
    .head_on_food (hof),
    .food_on_body (fob),
    .game_state   (game_state),
    .init_pulse   (init_pulse),
    .move_tick    (move_tick),
    .dir          (dir),
    .grow_req     (grow_req),
    .food_respawn (food_respawn),
    .snake_len    (snake_len)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  // strobe vector order: {init_pulse, move_tick, grow_req, food_respawn}
  typedef struct {
    int         c;
    logic [2:0] st;
    logic [3:0] stb;
    logic [1:0] d;
    logic [3:0] len;
  } ev_t;

  ev_t q[$];

  task automatic push(input int c, input logic [2:0] st,
                      input logic [3:0] stb, input logic [1:0] d,
                      input logic [3:0] len);
    ev_t e;
    e.c = c;
    e.st = st;
    e.stb = stb;
    e.d = d;
    e.len = len;
    q.push_back(e);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  logic [3:0] stb;
  logic [2:0] prev_st = 3'd0;

  always @(negedge clk) begin
    ev_t e;
    stb = {init_pulse, move_tick, grow_req, food_respawn};
    if (stb != 4'd0 || game_state != prev_st) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event cyc=%0d st=%0d stb=%b dir=%0d len=%0d",
                 cyc, game_state, stb, dir, snake_len);
      end else begin
        e = q.pop_front();
        if (e.c != cyc || e.st !== game_state || e.stb !== stb ||
            e.d !== dir || e.len !== snake_len) begin
          errors++;
          $display("FAIL event got cyc=%0d st=%0d stb=%b dir=%0d len=%0d expected cyc=%0d st=%0d stb=%b dir=%0d len=%0d",
                   cyc, game_state, stb, dir, snake_len,
                   e.c, e.st, e.stb, e.d, e.len);
        end
      end
    end
    prev_st = game_state;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) step();
  endtask

  task automatic key(input logic [3:0] k);
    key_out = k;
    step();
    key_out = 4'd0;
  endtask

  int c0;
  int r;

  initial begin
    repeat (3) step();
    rst_n = 1'b1;
    chk("rst_state", int'(game_state), 0);
    chk("rst_len", int'(snake_len), 4);
    chk("rst_dir", int'(dir), 0);
    chk("rst_strobes",
        int'({init_pulse, move_tick, grow_req, food_respawn}), 0);
    step();
    step();

    // hard start, 4-cycle move period
    c0 = cyc;
    r = c0 + 2;
    push(c0 + 1, INIT, 4'b1000, 2'd0, 4'd4);
    push(r, RUN, 4'b0000, 2'd0, 4'd4);
    push(r + 4, RUN, 4'b0100, 2'd0, 4'd4);
    key(4'd1);

    // up then left within one period: left would reverse, dropped
    push(r + 8, RUN, 4'b0100, 2'd3, 4'd4);
    push(r + 12, RUN, 4'b0100, 2'd0, 4'd4);
    wait_until(r + 5);
    key(4'd1);
    key(4'd3);
    wait_until(r + 9);
    key(4'd4);

    // food held 10 cycles: a single grow
    push(r + 14, RUN, 4'b0010, 2'd0, 4'd5);
    push(r + 16, RUN, 4'b0100, 2'd0, 4'd5);
    push(r + 20, RUN, 4'b0100, 2'd0, 4'd5);
    push(r + 24, RUN, 4'b0100, 2'd0, 4'd5);
    wait_until(r + 13);
    hof = 1'b1;
    wait_until(r + 23);
    hof = 1'b0;

    // food overlapping body: respawn every 2nd cycle
    push(r + 26, RUN, 4'b0001, 2'd0, 4'd5);
    push(r + 28, RUN, 4'b0101, 2'd0, 4'd5);
    push(r + 30, RUN, 4'b0001, 2'd0, 4'd5);
    push(r + 32, RUN, 4'b0100, 2'd0, 4'd5);
    wait_until(r + 25);
    fob = 1'b1;
    wait_until(r + 30);
    fob = 1'b0;

    // pause at cnt==2 with hit pulsed while paused, then pause on due tick
    push(r + 35, PAUS, 4'b0000, 2'd0, 4'd5);
    push(r + 56, RUN, 4'b0000, 2'd0, 4'd5);
    push(r + 58, RUN, 4'b0100, 2'd0, 4'd5);
    push(r + 62, PAUS, 4'b0000, 2'd0, 4'd5);
    push(r + 65, RUN, 4'b0000, 2'd0, 4'd5);
    push(r + 66, RUN, 4'b0100, 2'd0, 4'd5);
    wait_until(r + 34);
    key(4'd5);
    wait_until(r + 40);
    hit = 1'b1;
    wait_until(r + 45);
    hit = 1'b0;
    wait_until(r + 55);
    key(4'd5);
    wait_until(r + 61);
    key(4'd5);
    wait_until(r + 64);
    key(4'd5);

    // grow to the 10-segment limit, sixth eat is ignored
    push(r + 68, RUN, 4'b0010, 2'd0, 4'd6);
    push(r + 70, RUN, 4'b0110, 2'd0, 4'd7);
    push(r + 72, RUN, 4'b0010, 2'd0, 4'd8);
    push(r + 74, RUN, 4'b0110, 2'd0, 4'd9);
    push(r + 76, RUN, 4'b0010, 2'd0, 4'd10);
    push(r + 78, RUN, 4'b0100, 2'd0, 4'd10);
    for (int i = 0; i < 6; i++) begin
      wait_until(r + 67 + 2 * i);
      hof = 1'b1;
      step();
      hof = 1'b0;
    end

    // hit with eat on a due tick: OVER only; steering ignored; S2 -> IDLE
    push(r + 82, OVER, 4'b0000, 2'd0, 4'd10);
    push(r + 87, IDLE, 4'b0000, 2'd0, 4'd10);
    wait_until(r + 81);
    hit = 1'b1;
    hof = 1'b1;
    wait_until(r + 83);
    hit = 1'b0;
    hof = 1'b0;
    wait_until(r + 84);
    key(4'd1);
    wait_until(r + 86);
    key(4'd5);

    // medium game, async reset mid-RUN, then easy game
    push(r + 89, INIT, 4'b1000, 2'd0, 4'd4);
    push(r + 90, RUN, 4'b0000, 2'd0, 4'd4);
    push(r + 96, RUN, 4'b0100, 2'd3, 4'd4);
    push(r + 98, IDLE, 4'b0000, 2'd0, 4'd4);
    push(r + 103, INIT, 4'b1000, 2'd0, 4'd4);
    push(r + 104, RUN, 4'b0000, 2'd0, 4'd4);
    push(r + 112, RUN, 4'b0100, 2'd0, 4'd4);
    wait_until(r + 88);
    key(4'd2);
    wait_until(r + 91);
    key(4'd1);
    wait_until(r + 98);
    rst_n = 1'b0;
    wait_until(r + 100);
    rst_n = 1'b1;
    wait_until(r + 102);
    key(4'd3);
    wait_until(r + 115);

    chk("events_left", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
